// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns a valid/ready command into one APB
// SETUP/ACCESS transfer, with wait states, PSLVERR and a hung-slave timeout.
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NBYTES         = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [NBYTES-1:0]     cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [NBYTES-1:0]     PSTRB,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // state    | meaning
  // S_IDLE   | no transfer, cmd_ready high
  // S_SETUP  | APB setup phase (PSELx=1, PENABLE=0), timeout counter cleared
  // S_ACCESS | APB access phase, waiting for PREADY or timeout
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NBYTES-1:0]     pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid) begin
          state_d  = S_SETUP;
          psel_d   = 1'b1;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      S_ACCESS: begin
        // PREADY is checked first so a ready slave beats a simultaneous expiry
        if (PREADY) begin
          state_d       = S_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_error_d   = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        end else if (cnt_q == TO_LIMIT) begin
          state_d       = S_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Gated by PRESETn so the port reads 0 while reset is held and 1 as soon as it lifts
  assign cmd_ready   = PRESETn && (state_q == S_IDLE);
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
